// File: rtl/sram_pkg.sv
// Shared types and helpers for the byte-enable dual-port SRAM.
// Latency: none (types, constants and pure functions only).
// Backpressure: none.
package sram_pkg;

   // Clear sequencer states: sweeping the array, or open for user traffic.
   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } init_state_e;

   // Address width for a given depth; depth need not be a power of two.
   function automatic int aw_of(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // One enable bit per data byte.
   function automatic int bw_of(input int width);
      return width / 8;
   endfunction

   // Byte-lane merge: take the new byte where enabled, keep the old one elsewhere.
   function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                             input logic [7:0] new_b,
                                             input logic       en);
      return en ? new_b : old_b;
   endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return pipeline carrying {valid, collision, data} from the array register to the port.
// Latency: RD_LAT cycles (1 or 2), one register per stage.
// Backpressure: none; a new read may enter every cycle and data holds between reads.
module sram_rd_pipe #(
   parameter int WIDTH  = 32,
   parameter int RD_LAT = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_vld,
   input  logic             in_col,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   output logic             out_col,
   output logic [WIDTH-1:0] out_dat
);

   logic [RD_LAT-1:0] vld_q;
   logic [RD_LAT-1:0] col_q;
   logic [WIDTH-1:0]  dat_q [RD_LAT];

   // Shift the read returns; data only moves with a valid read so the last word is held.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_q <= '0;
         col_q <= '0;
         for (int s = 0; s < RD_LAT; s++) dat_q[s] <= '0;
      end else begin
         vld_q[0] <= in_vld;
         col_q[0] <= in_vld & in_col;
         if (in_vld) dat_q[0] <= in_dat;
         for (int s = 1; s < RD_LAT; s++) begin
            vld_q[s] <= vld_q[s-1];
            col_q[s] <= col_q[s-1];
            if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
         end
      end
   end

   assign out_vld = vld_q[RD_LAT-1];
   assign out_col = col_q[RD_LAT-1];
   assign out_dat = dat_q[RD_LAT-1];

endmodule

// File: rtl/sram_dp_be.sv
// Simple-dual-port SRAM with byte enables, clear sweep after reset/init_req; SRAM_WR_FWD_EN selects write-first collisions.
// Latency: read sampled at edge k returns after edge k+RD_LAT (array register + RD_LAT pipe stages); clear takes DEPTH cycles.
// Backpressure: none; reads/writes accepted every cycle in IDLE, silently ignored while init_busy is high.
module sram_dp_be
   import sram_pkg::*;
#(
   parameter int  WIDTH  = 32,
   parameter int  DEPTH  = 1024,
   parameter int  RD_LAT = 1,
   localparam int AW     = aw_of(DEPTH),
   localparam int BW     = bw_of(WIDTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             init_req,
   output logic             init_busy,
   input  logic             wren,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [BW-1:0]    wr_be,
   input  logic             rden,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             collision
);

   // Counter is one bit wider than the address so a power-of-two depth never wraps.
   localparam logic [AW:0] LAST    = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   init_state_e      state, state_nxt;
   logic [AW:0]      cnt, cnt_nxt;
   logic             idle, wr_ok, rd_ok, rd_in_range, coll;
   logic [WIDTH-1:0] wr_old, wr_merged, rd_word;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             s0_vld, s0_col;
   logic [WIDTH-1:0] s0_dat;

   assign idle        = (state == IDLE);
   assign init_busy   = (state == CLEAR);
   assign wr_ok       = wren && idle && ({1'b0, wr_addr} < DEPTH_W);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
   assign rd_ok       = rden && idle;
   assign coll        = wr_ok && rd_ok && rd_in_range && (wr_addr == rd_addr);

   // Clear sequencer state and sweep counter.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Sweep every address once, then open for traffic; init_req restarts the sweep from IDLE only.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         CLEAR: begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end
         end
         IDLE: begin
            if (init_req) begin
               state_nxt = CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign wr_old = mem[wr_addr];

   // Byte-merged write word; also the forwarded word on a write-first collision.
   always_comb begin
      wr_merged = wr_old;
      for (int b = 0; b < BW; b++)
         wr_merged[8*b +: 8] = merge_byte(wr_old[8*b +: 8], wr_data[8*b +: 8], wr_be[b]);
   end

   // Word presented to the read register: zero when out of range, collision policy per build.
   always_comb begin
      rd_word = '0;
      if (rd_in_range) begin
`ifdef SRAM_WR_FWD_EN
         rd_word = coll ? wr_merged : mem[rd_addr];
`else
         rd_word = mem[rd_addr];
`endif
      end
   end

   // Array write port (sweep wins over user writes) and synchronous read register.
   always_ff @(posedge clk) begin
      if (!idle)
         mem[cnt[AW-1:0]] <= '0;
      else if (wr_ok)
         mem[wr_addr] <= wr_merged;
      if (rd_ok)
         s0_dat <= rd_word;
   end

   // Read-launch strobe and collision flag, aligned with the read register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s0_vld <= 1'b0;
         s0_col <= 1'b0;
      end else begin
         s0_vld <= rd_ok;
         s0_col <= coll;
      end
   end

   sram_rd_pipe #(
      .WIDTH  (WIDTH),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rstn    (rstn),
      .in_vld  (s0_vld),
      .in_col  (s0_col),
      .in_dat  (s0_dat),
      .out_vld (rd_valid),
      .out_col (collision),
      .out_dat (rd_data)
   );

endmodule

// File: tb/tb_sram_dp_be.sv
// Bench for sram_dp_be: one instance at DEPTH=1024/RD_LAT=1, one at DEPTH=1000/RD_LAT=2, sharing stimulus.
// Expected reads come from a reference array per instance and are queued with their due cycle.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_sram_dp_be;

   localparam int DA = 1024;
   localparam int DB = 1000;
   localparam int LA = 1;
   localparam int LB = 2;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        init_req = 1'b0;
   logic        wren = 1'b0;
   logic        rden = 1'b0;
   logic [9:0]  wr_addr = '0;
   logic [9:0]  rd_addr = '0;
   logic [31:0] wr_data = '0;
   logic [3:0]  wr_be = '0;

   logic        busy_a, vld_a, col_a;
   logic [31:0] rdd_a;
   logic        busy_b, vld_b, col_b;
   logic [31:0] rdd_b;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [31:0] dat;
      logic        col;
      int          due;
   } exp_t;

   exp_t        q_a[$];
   exp_t        q_b[$];
   logic [31:0] mdl_a [DA];
   logic [31:0] mdl_b [DB];

   sram_dp_be #(.WIDTH(32), .DEPTH(DA), .RD_LAT(LA)) dut_a (
      .clk(clk), .rstn(rstn), .init_req(init_req), .init_busy(busy_a),
      .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rden(rden), .rd_addr(rd_addr), .rd_data(rdd_a), .rd_valid(vld_a), .collision(col_a)
   );

   sram_dp_be #(.WIDTH(32), .DEPTH(DB), .RD_LAT(LB)) dut_b (
      .clk(clk), .rstn(rstn), .init_req(init_req), .init_busy(busy_b),
      .wren(wren), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rden(rden), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_valid(vld_b), .collision(col_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] bmerge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // Scoreboard: every rd_valid must match the oldest queued expectation, on its due cycle.
   always @(negedge clk) begin
      exp_t ea, eb;
      if (vld_a) begin
         chk("a_vld_expected", q_a.size() != 0, 1'b1);
         if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            chk("a_rd_data", rdd_a, ea.dat);
            chk("a_collision", col_a, ea.col);
            chk("a_latency", cyc, ea.due);
         end
      end
      if (vld_b) begin
         chk("b_vld_expected", q_b.size() != 0, 1'b1);
         if (q_b.size() != 0) begin
            eb = q_b.pop_front();
            chk("b_rd_data", rdd_b, eb.dat);
            chk("b_collision", col_b, eb.col);
            chk("b_latency", cyc, eb.due);
         end
      end
   end

   // One cycle of stimulus; acc says whether the DUTs are expected to accept it (IDLE).
   task automatic step(input logic we, input logic [9:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [9:0] ra,
                       input logic ir, input logic acc);
      exp_t e;
      logic hit;
      @(negedge clk);
      wren = we; wr_addr = wa; wr_data = wd; wr_be = be;
      rden = re; rd_addr = ra; init_req = ir;
      if (acc) begin
         if (re) begin
            hit   = we && (wa == ra);
            e.dat = mdl_a[ra];
`ifdef SRAM_WR_FWD_EN
            if (hit) e.dat = bmerge(mdl_a[ra], wd, be);
`endif
            e.col = hit;
            e.due = cyc + 1 + LA;
            q_a.push_back(e);

            hit   = we && (wa == ra) && (ra < DB);
            e.dat = '0;
            if (ra < DB) e.dat = mdl_b[ra];
`ifdef SRAM_WR_FWD_EN
            if (hit) e.dat = bmerge(mdl_b[ra], wd, be);
`endif
            e.col = hit;
            e.due = cyc + 1 + LB;
            q_b.push_back(e);
         end
         if (we) begin
            mdl_a[wa] = bmerge(mdl_a[wa], wd, be);
            if (wa < DB) mdl_b[wa] = bmerge(mdl_b[wa], wd, be);
         end
         if (ir) begin
            for (int i = 0; i < DA; i++) mdl_a[i] = '0;
            for (int i = 0; i < DB; i++) mdl_b[i] = '0;
         end
      end
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
      step(1'b1, a, d, be, 1'b0, 10'd0, 1'b0, 1'b1);
   endtask

   task automatic rd(input logic [9:0] a);
      step(1'b0, 10'd0, 32'd0, 4'd0, 1'b1, a, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 10'd0, 32'd0, 4'd0, 1'b0, 10'd0, 1'b0, 1'b1);
   endtask

   task automatic rst_checks(input string tag);
      chk({tag, "_busy_a"}, busy_a, 1'b1);
      chk({tag, "_busy_b"}, busy_b, 1'b1);
      chk({tag, "_vld_a"}, vld_a, 1'b0);
      chk({tag, "_vld_b"}, vld_b, 1'b0);
      chk({tag, "_col_a"}, col_a, 1'b0);
      chk({tag, "_col_b"}, col_b, 1'b0);
      chk({tag, "_data_a"}, rdd_a, 32'h0);
      chk({tag, "_data_b"}, rdd_b, 32'h0);
   endtask

   // fall_a: number of rising edges from now after which dut_a's busy drops; dut_b drops DA-DB earlier.
   task automatic sweep_check(input string tag, input int fall_a);
      int fall_b;
      fall_b = fall_a - (DA - DB);
      repeat (fall_b - 1) @(negedge clk);
      chk({tag, "_b_busy_last"}, busy_b, 1'b1);
      chk({tag, "_a_busy_mid"}, busy_a, 1'b1);
      @(negedge clk);
      chk({tag, "_b_busy_done"}, busy_b, 1'b0);
      repeat (fall_a - fall_b - 1) @(negedge clk);
      chk({tag, "_a_busy_last"}, busy_a, 1'b1);
      @(negedge clk);
      chk({tag, "_a_busy_done"}, busy_a, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < DA; i++) mdl_a[i] = '0;
      for (int i = 0; i < DB; i++) mdl_b[i] = '0;

      // Reset values, then the power-on sweep length.
      repeat (3) @(negedge clk);
      rst_checks("rst");
      @(negedge clk);
      rstn = 1'b1;
      sweep_check("sweep_por", DA);

      // Freshly cleared array; 0x3FF is out of range on the 1000-word instance.
      rd(10'h000); rd(10'h1FF); rd(10'h3FF);
      idle(1);

      // Byte-enable merge, then an all-disabled write that must change nothing.
      wr(10'h010, 32'hDEADBEEF, 4'b1111);
      wr(10'h010, 32'h000000AA, 4'b0001);
      rd(10'h010);
      wr(10'h010, 32'hFFFFFFFF, 4'b0000);
      rd(10'h010);
      idle(4);
      chk("hold_a", rdd_a, 32'hDEADBEAA);
      chk("hold_b", rdd_b, 32'hDEADBEAA);

      // Same-address write/read collision, then the written result.
      wr(10'h020, 32'h11111111, 4'b1111);
      step(1'b1, 10'h020, 32'h22222222, 4'b0011, 1'b1, 10'h020, 1'b0, 1'b1);
      rd(10'h020);
      idle(1);

      // Back-to-back reads with no gaps.
      for (int i = 0; i < 16; i++) wr(10'(i), 32'(i + 1), 4'b1111);
      for (int i = 0; i < 16; i++) rd(10'(i));
      idle(4);

      // Address 1000: in range for dut_a, dropped / zero-read for dut_b.
      wr(10'd1000, 32'h12345678, 4'b1111);
      rd(10'd1000);
      idle(4);

      // init_req sweep with traffic (and a second init_req) driven while busy.
      wr(10'h005, 32'h00000055, 4'b1111);
      step(1'b0, 10'd0, 32'd0, 4'd0, 1'b0, 10'd0, 1'b1, 1'b1);
      step(1'b1, 10'h005, 32'h00000077, 4'b1111, 1'b1, 10'h005, 1'b0, 1'b0);
      step(1'b1, 10'h006, 32'h00000088, 4'b1111, 1'b1, 10'h005, 1'b1, 1'b0);
      step(1'b0, 10'd0, 32'd0, 4'd0, 1'b0, 10'd0, 1'b0, 1'b0);
      sweep_check("sweep_req", DA - 2);
      rd(10'h005); rd(10'h006); rd(10'h010);
      idle(4);

      // Reset in the middle of a sweep restarts it for a full DEPTH cycles.
      wr(10'h300, 32'h00000099, 4'b1111);
      rd(10'h300);
      step(1'b0, 10'd0, 32'd0, 4'd0, 1'b0, 10'd0, 1'b1, 1'b1);
      idle(0);
      step(1'b0, 10'd0, 32'd0, 4'd0, 1'b0, 10'd0, 1'b0, 1'b0);
      repeat (300) @(negedge clk);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rst_checks("rst_mid");
      rstn = 1'b1;
      sweep_check("sweep_rst", DA);
      rd(10'h300);
      idle(4);

      chk("a_queue_drained", q_a.size(), 0);
      chk("b_queue_drained", q_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_dp_be.md
# sram_dp_be

Parametrised simple-dual-port SRAM, successor to the single-width `sram` block. It adds:
- per-byte write enables;
- a configurable read pipeline with a `rd_valid` strobe;
- a hardware clear sequencer that zeroes the array after reset or on request;
- defined same-address read/write collision behaviour.

It sits between bus-side masters and on-chip storage wherever the team needs a scratchpad or buffer RAM.

## Interface
Parameters:
- WIDTH, 32, data width in bits; must be a multiple of 8
- DEPTH, 1024, number of words; need not be a power of two
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- AW, $clog2(DEPTH), address width (derived, not overridden)
- BW, WIDTH/8, byte-enable width (derived)

Ports:
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous assert, active-low
- init_req  in  1  pulse: restart clear sweep (honoured only in IDLE)
- init_busy  out  1  clear sweep in progress; user accesses ignored
- wren  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- wr_be  in  BW  byte enables; bit i covers wr_data[8i+7:8i]
- rden  in  1  read strobe
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  read data; holds its last value when no read completes
- rd_valid  out  1  one-cycle pulse: rd_data is new
- collision  out  1  pulse aligned with rd_valid: this read hit the same-cycle write address

## Operation
- Init FSM has two states, CLEAR and IDLE.
- Reset drives the FSM to CLEAR with the sweep counter at 0.
- CLEAR:
  - writes all-zero to address cnt each cycle and increments cnt;
  - at cnt == DEPTH-1, writes that last address and moves to IDLE.
- IDLE + init_req=1: moves to CLEAR with cnt=0.
- init_busy = (state == CLEAR).
- While init_busy=1:
  - wren and rden are ignored;
  - no rd_valid is produced;
  - init_req is ignored.
- Write: wren=1 in IDLE updates only the bytes whose wr_be bit is 1. wr_be=0 writes nothing.
- Read: rden=1 in IDLE launches a read. Back-to-back reads are allowed every cycle, fully pipelined.
- Out-of-range address (addr >= DEPTH):
  - write is dropped;
  - read returns 0 with rd_valid=1.
- Collision: wren && rden && wr_addr == rd_addr, both in range and accepted.
  - collision=1 alongside that read's rd_valid.
  - rd_data returns the pre-write word (read-first) unless SRAM_WR_FWD_EN is defined.
- Reset mid-sweep or mid-read: all state aborts; reads in flight are lost. Array contents are not reset directly; the sweep clears them.

## Timing
- Reset values: init_busy=1, rd_data=0, rd_valid=0, collision=0, state=CLEAR, cnt=0. The read pipeline valid bits are 0.
- The clear sweep takes exactly DEPTH cycles from the first rising edge after rstn deasserts. init_busy falls after edge DEPTH.
- Read sampled at edge k:
  - RD_LAT=1: rd_data/rd_valid/collision are valid after edge k+1.
  - RD_LAT=2: they are valid after edge k+2.
- Write sampled at edge k is visible to any read sampled at edge k+1 or later.
- rd_valid and collision are single-cycle pulses per read. Continuous reads give continuous rd_valid.
- Sweep counter width is AW+1, so there is no wrap at DEPTH = 2^AW.

## Configuration
- Macro: SRAM_WR_FWD_EN.
- Defined: collisions are write-first. rd_data = new bytes where wr_be=1 and old bytes elsewhere, byte-merged.
- Undefined: collisions are read-first; rd_data = the old word.
- collision is asserted in both builds.

## Structure
- Package sram_pkg holds:
  - init FSM state enum (CLEAR, IDLE);
  - localparam functions for AW/BW derivation;
  - the byte-merge function used for writes and forwarding.
- One sub-module, sram_rd_pipe: a RD_LAT-deep register chain carrying {valid, collision, data}, with async active-low reset.
- The storage array and init FSM live in sram_dp_be.

## Test plan
- Reset release, no stimulus -> init_busy=1 for exactly 1024 cycles, then 0. Reads of addresses 0x000, 0x1FF and 0x3FF all return 0x00000000.
- Write 0xDEADBEEF to 0x010 with wr_be=4'b1111, then write 0x000000AA with wr_be=4'b0001 -> read of 0x010 returns 0xDEADBEAA, with rd_valid after RD_LAT cycles (test both RD_LAT=1 and RD_LAT=2).
- Address 0x020 holds 0x11111111; same-cycle write of 0x22222222 (wr_be=4'b0011) and read of 0x020 -> collision=1, and:
  - rd_data=0x11111111 without SRAM_WR_FWD_EN;
  - rd_data=0x11112222 with it.
- 16 back-to-back reads of addresses 0x0–0xF, pre-written with 0x1–0x10 -> 16 consecutive rd_valid pulses with data in order, no gaps.
- Write 0x55 to 0x005, then pulse init_req; wren/rden driven during the sweep -> accesses ignored, no rd_valid. After the sweep, 0x005 reads as 0.
- DEPTH=1000: write 0x12345678 to address 1000 -> dropped; read of address 1000 returns 0 with rd_valid=1. Also assert rstn mid-sweep -> sweep restarts at cnt=0 and takes a full 1000 cycles.
